// File: rtl/day_of_year_decoder_if.sv
// Handshake and data bundle for the day-of-year to month/day decoder.
// The master drives the start request; the slave returns status and BCD results.
interface day_of_year_decoder_if;
  logic        start;
  logic [11:0] doy_bcd;
  logic        leap;
  logic        busy;
  logic        done;
  logic        valid;
  logic        err;
  logic [7:0]  month_bcd;
  logic [7:0]  dom_bcd;

  modport master (
    output start, doy_bcd, leap,
    input  busy, done, valid, err, month_bcd, dom_bcd
  );

  modport slave (
    input  start, doy_bcd, leap,
    output busy, done, valid, err, month_bcd, dom_bcd
  );
endinterface

// File: rtl/day_of_year_decoder.sv
// Converts a BCD day-of-year into BCD month and day-of-month by subtracting
// one month length per clock until the remainder fits in the current month.
module day_of_year_decoder (
  input logic                  clk,
  input logic                  reset,
  day_of_year_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StWalk, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] doy_q, doy_d;
  logic        leap_q, leap_d;
  logic [8:0]  rem_q, rem_d;
  logic [3:0]  mon_q, mon_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  dom_q, dom_d;

  logic [10:0] doy_bin;
  logic        digit_bad;
  logic [8:0]  doy_max;
  logic [4:0]  len;

  function automatic logic [4:0] month_len(input logic [3:0] mon, input logic lp);
    case (mon)
      4'd2:                    month_len = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      default:                 month_len = 5'd31;
    endcase
  endfunction

  // Values never exceed 31, so the tens digit is at most 3.
  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [3:0] tens;
    logic [4:0] base;
    if (v >= 5'd30) begin
      tens = 4'd3;
      base = 5'd30;
    end else if (v >= 5'd20) begin
      tens = 4'd2;
      base = 5'd20;
    end else if (v >= 5'd10) begin
      tens = 4'd1;
      base = 5'd10;
    end else begin
      tens = 4'd0;
      base = 5'd0;
    end
    to_bcd = {tens, 4'(v - base)};
  endfunction

  // 11 bits so that illegal digits up to 0xF cannot wrap into the legal range.
  assign doy_bin   = 11'(doy_q[11:8]) * 11'd100 + 11'(doy_q[7:4]) * 11'd10 + 11'(doy_q[3:0]);
  assign digit_bad = (doy_q[11:8] > 4'd9) || (doy_q[7:4] > 4'd9) || (doy_q[3:0] > 4'd9);
  assign doy_max   = leap_q ? 9'd366 : 9'd365;
  assign len       = month_len(mon_q, leap_q);

  always_comb begin
    state_d = state_q;
    doy_d   = doy_q;
    leap_d  = leap_q;
    rem_d   = rem_q;
    mon_d   = mon_q;
    valid_d = valid_q;
    err_d   = err_q;
    month_d = month_q;
    dom_d   = dom_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          doy_d   = bus.doy_bcd;
          leap_d  = bus.leap;
          state_d = StLoad;
        end
      end
      StLoad: begin
        rem_d = doy_bin[8:0];
        mon_d = 4'd1;
        if (digit_bad || doy_bin == 11'd0 || doy_bin > {2'b00, doy_max}) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (rem_q > {4'd0, len}) begin
          rem_d = rem_q - {4'd0, len};
          mon_d = mon_q + 4'd1;
        end else begin
          valid_d = 1'b1;
          err_d   = 1'b0;
          month_d = to_bcd({1'b0, mon_q});
          dom_d   = to_bcd(rem_q[4:0]);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      doy_q   <= 12'h000;
      leap_q  <= 1'b0;
      rem_q   <= 9'd0;
      mon_q   <= 4'd1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      month_q <= 8'h01;
      dom_q   <= 8'h01;
    end else begin
      state_q <= state_d;
      doy_q   <= doy_d;
      leap_q  <= leap_d;
      rem_q   <= rem_d;
      mon_q   <= mon_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      month_q <= month_d;
      dom_q   <= dom_d;
    end
  end

  assign bus.busy      = (state_q == StLoad) || (state_q == StWalk);
  assign bus.done      = (state_q == StDone);
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.month_bcd = month_q;
  assign bus.dom_bcd   = dom_q;

endmodule
